// File: rtl/cs_pkg.sv
// Shared constants for the CS smoothing core and its output buffer.
package cs_pkg;

   localparam int CS_XW     = 8;           // input sample width
   localparam int CS_YW     = 10;          // smoothed result width
   localparam int CS_WIN    = 9;           // smoothing window length
   localparam int CS_WARMUP = CS_WIN - 1;  // results produced before the window is full

endpackage

// File: rtl/cs_sync_fifo.sv
// Generic show-ahead register-array FIFO.
// The head entry is always visible on dout.
// dout reads 0 while the FIFO is empty.
// Occupancy is tracked in its own counter, so full and empty are never ambiguous.
module cs_sync_fifo #(
   parameter int DW    = 10,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DW-1:0]              din,
   output logic [DW-1:0]              dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_nxt;
   logic          full_q;
   logic          empty_q;
   logic          do_push;
   logic          do_pop;

   // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
   assign do_pop  = pop && !empty_q;
   assign do_push = push && (!full_q || do_pop);

   // Next occupancy; flush wins over any push or pop.
   always_comb begin
      count_nxt = count_q;
      if (flush) begin
         count_nxt = '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
         endcase
      end
   end

   // Storage array; it needs no reset because empty_q masks stale contents.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers, occupancy and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         end
         count_q <= count_nxt;
         full_q  <= (count_nxt == CW'(DEPTH));
         empty_q <= (count_nxt == '0);
      end
   end

   assign dout  = empty_q ? '0 : mem[rd_ptr];
   assign count = count_q;
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/cs_out_buf.sv
// Output buffer for the CS smoothing core.
// It discards the warm-up results and queues the valid results.
// Queued results drain through a valid/ready port.
// Results that arrive while the queue is full and not draining are counted as drops.
//
// Handshake: a result moves to the consumer on a rising edge where dout_vld
// and dout_rdy are both high. dout_vld never depends on dout_rdy, and
// dout holds its value while dout_vld is high and dout_rdy is low.
module cs_out_buf
   import cs_pkg::*;
#(
   parameter int DW     = CS_YW,
   parameter int DEPTH  = 16,
   parameter int WARMUP = CS_WARMUP
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DW-1:0]          y,
   input  logic                   y_vld,
   input  logic                   flush,
   output logic [DW-1:0]          dout,
   output logic                   dout_vld,
   input  logic                   dout_rdy,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   ovf,
   output logic [7:0]             drop_cnt
);

   logic [3:0] warm_cnt;
   logic       run;
   logic       push_req;
   logic       pop;
   logic       drop;
   logic       fifo_empty;
   logic       ovf_q;
   logic [7:0] drop_cnt_q;

   assign run      = (warm_cnt == 4'(WARMUP));
   assign pop      = dout_vld && dout_rdy;
   assign push_req = y_vld && run && !flush;
   assign drop     = push_req && full && !pop;

   // Count incoming results until the smoothing window is full, then hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         warm_cnt <= '0;
      end else if (flush) begin
         warm_cnt <= '0;
      end else if (y_vld && !run) begin
         warm_cnt <= warm_cnt + 4'd1;
      end
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else if (flush) begin
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop) begin
         ovf_q <= 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   cs_sync_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .flush (flush),
      .push  (push_req),
      .pop   (pop),
      .din   (y),
      .dout  (dout),
      .count (count),
      .full  (full),
      .empty (fifo_empty)
   );

   assign dout_vld = !fifo_empty;
   assign ovf      = ovf_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_cs_out_buf.sv
// Self-checking bench for cs_out_buf.
// A reference queue models the buffered results.
module tb_cs_out_buf;

   localparam int DW     = 10;
   localparam int DEPTH  = 16;
   localparam int WARMUP = 8;

   logic          clk;
   logic          reset;
   logic [DW-1:0] y;
   logic          y_vld;
   logic          flush;
   logic [DW-1:0] dout;
   logic          dout_vld;
   logic          dout_rdy;
   logic [4:0]    count;
   logic          full;
   logic          ovf;
   logic [7:0]    drop_cnt;

   // reference model
   logic [DW-1:0] exp_q[$];
   int            m_warm;
   logic          m_ovf;
   int            m_drop;

   int checks;
   int errors;

   cs_out_buf #(
      .DW     (DW),
      .DEPTH  (DEPTH),
      .WARMUP (WARMUP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .y        (y),
      .y_vld    (y_vld),
      .flush    (flush),
      .dout     (dout),
      .dout_vld (dout_vld),
      .dout_rdy (dout_rdy),
      .count    (count),
      .full     (full),
      .ovf      (ovf),
      .drop_cnt (drop_cnt)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_warm = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
   endtask

   // Compare every registered output with the model state.
   task automatic check_state();
      int sz;
      sz = exp_q.size();
      chk("dout_vld", dout_vld, (sz > 0));
      chk("count", count, sz);
      chk("full", full, (sz == DEPTH));
      chk("ovf", ovf, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      if (sz > 0) chk("dout_head", dout, exp_q[0]);
      else        chk("dout_empty", dout, 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_dout"}, dout, 0);
      chk({tag, "_vld"}, dout_vld, 0);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_full"}, full, 0);
      chk({tag, "_ovf"}, ovf, 0);
      chk({tag, "_drop"}, drop_cnt, 0);
   endtask

   // Driver: called at a falling edge.
   // Each call checks outputs, drives inputs for the next rising edge and updates the model.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
      int            sz;
      logic          pop_now;
      logic [DW-1:0] e;
      check_state();
      y_vld    = v;
      y        = d;
      dout_rdy = r;
      flush    = f;
      sz = exp_q.size();
      if (f) begin
         model_clear();
      end else begin
         pop_now = r && (sz > 0);
         if (pop_now) begin
            e = exp_q.pop_front();
            chk("pop_data", dout, e);
         end
         if (v) begin
            if (m_warm < WARMUP) begin
               m_warm++;
            end else if (sz < DEPTH || pop_now) begin
               exp_q.push_back(d);
            end else begin
               m_ovf = 1'b1;
               if (m_drop < 255) m_drop++;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic r, input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, r, 1'b0);
   endtask

   // Assert reset at a non-edge time, check outputs at once, then release at a falling edge.
   task automatic pulse_reset();
      #2 reset = 1'b0;
      #1 check_zero("async_rst");
      y_vld = 1'b0; flush = 1'b0; dout_rdy = 1'b0; y = '0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      check_zero("rst_hold");
      reset = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      model_clear();
      reset = 1'b0; y = '0; y_vld = 1'b0; flush = 1'b0; dout_rdy = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b1;

      // warm-up then streaming with consumer ready
      for (int i = 1; i <= 20; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
      idle(1'b1, 2);

      // fill with consumer stalled, one drop, then drain
      for (int i = 0; i < 16; i++) step(1'b1, DW'(10'h100 + i), 1'b0, 1'b0);
      step(1'b1, 10'h110, 1'b0, 1'b0);
      idle(1'b0, 1);
      chk("fill_full", full, 1);
      chk("fill_ovf", ovf, 1);
      chk("fill_drop", drop_cnt, 1);
      idle(1'b1, 18);

      // full with simultaneous push and pop
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < WARMUP; i++) step(1'b1, 10'h3AA, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b1, DW'(10'h200 + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, DW'(10'h210 + i), 1'b1, 1'b0);
      chk("pp_count", count, 16);
      chk("pp_drop", drop_cnt, 0);

      // flush together with y_vld at count 5
      idle(1'b1, 11);
      chk("pre_flush_count", count, 5);
      step(1'b1, 10'h3FF, 1'b1, 1'b1);
      for (int i = 0; i < WARMUP; i++) step(1'b1, DW'(10'h050 + i), 1'b1, 1'b0);

      // reset pulse mid-drain at count 7
      for (int i = 0; i < 9; i++) step(1'b1, DW'(10'h060 + i), 1'b0, 1'b0);
      idle(1'b1, 2);
      chk("pre_rst_count", count, 7);
      pulse_reset();
      for (int i = 0; i < WARMUP + 4; i++) step(1'b1, DW'(10'h070 + i), 1'b1, 1'b0);
      idle(1'b1, 2);

      // drop counter saturation
      for (int i = 0; i < 16; i++) step(1'b1, DW'(10'h080 + i), 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) step(1'b1, 10'h2AA, 1'b0, 1'b0);
      idle(1'b0, 1);
      chk("sat_drop", drop_cnt, 255);
      chk("sat_ovf", ovf, 1);
      idle(1'b1, 18);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), DW'($urandom_range(0, 1023)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
      end
      idle(1'b1, 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cs_out_buf.md
# cs_out_buf

Downstream output buffer for the CS smoothing core. It samples the 10-bit `Y` result stream, discards the warm-up results produced before the 9-sample window is full, and queues valid results in a small FIFO. The FIFO is drained through a valid/ready handshake towards the output interface. Overflow and drop conditions are reported so the system can detect a stalled consumer.

## Interface
- `DW`, 10: data width of `Y` and `dout`.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `WARMUP`, 8: number of accepted `Y` samples discarded after reset or flush.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `y`  in  DW: result from CS, updated once per cycle.
- `y_vld`  in  1: high when `y` carries a result for a newly sampled `X`.
- `flush`  in  1: synchronous clear of FIFO, warm-up counter and status.
- `dout`  out  DW: head-of-FIFO data.
- `dout_vld`  out  1: FIFO not empty.
- `dout_rdy`  in  1: consumer accepts `dout` when high with `dout_vld`.
- `count`  out  $clog2(DEPTH)+1: current occupancy.
- `full`  out  1: count == DEPTH.
- `ovf`  out  1: sticky; set when a result was dropped.
- `drop_cnt`  out  8: saturating count of dropped results.

## Operation
- Reset (reset = 0, async):
  - FIFO pointers = 0; count = 0; warm-up counter = 0.
  - `dout` = 0, `dout_vld` = 0, `full` = 0, `ovf` = 0, `drop_cnt` = 0.
- Warm-up phase:
  - A 4-bit counter increments on each `y_vld` until it reaches WARMUP, then saturates.
  - A `y_vld` cycle with counter < WARMUP discards the sample, with no push and no drop count.
- Run phase (counter == WARMUP): each `y_vld` cycle is a push request.
- Pop: occurs when `dout_vld && dout_rdy`.
- Push handling:
  - Push while not full: write at `wr_ptr`, then advance it.
  - Push while full with a simultaneous pop: both happen; count stays at DEPTH; no drop.
  - Push while full without a pop: the sample is dropped; `ovf` is set; `drop_cnt` increments, saturating at 255.
- Pop while empty: cannot occur, because `dout_vld` = 0.
- Pointers: `$clog2(DEPTH)` bits each, wrapping naturally. Count is tracked separately, so full and empty are never ambiguous.
- Flush:
  - Clears pointers, count, warm-up counter, `ovf` and `drop_cnt`.
  - Takes priority over a push or pop in the same cycle; that `y` sample is discarded.
- `dout` = mem[rd_ptr] when non-empty and 0 when empty. It is driven from registered storage, so there is no combinational path from `y` to `dout`.

## Timing
- `y` and `y_vld` are sampled on the rising edge.
- First accepted result:
  - The WARMUP+1-th `y_vld` sample after reset or flush.
  - It appears on `dout` with `dout_vld` = 1 one cycle after the sampling edge.
- Throughput: one push and one pop per cycle are sustained indefinitely.
- `count`, `full`, `ovf`, `drop_cnt` and `dout_vld` are registered and update on the edge following the event.
- `dout_rdy` may change in any cycle. `dout` is held stable while `dout_vld && !dout_rdy`.
- Asserting `reset` mid-burst immediately forces all outputs to their reset values. Release is synchronous to `clk`; the first push can occur on the edge after release.

## Structure
- Shared package `cs_pkg`:
  - `CS_XW` = 8, `CS_YW` = 10, `CS_WIN` = 9.
  - The derived warm-up constant `CS_WIN-1`, used as the `WARMUP` default.
- Sub-module `cs_sync_fifo`: generic show-ahead register-array FIFO with push, pop, flush, count and full/empty.
- `cs_out_buf` contains only the warm-up counter, drop/overflow logic and FIFO instance.

## Test plan
- Reset then 20 `y_vld` cycles carrying y = 0x001..0x014, with `dout_rdy` = 1:
  - The first 8 are discarded.
  - `dout` shows 0x009..0x014 in order, each one cycle after its input.
  - `count` stays ≤ 1.
- `dout_rdy` = 0 while pushing 16 post-warm-up values 0x100..0x10F:
  - `full` = 1 and `count` = 16.
  - The 17th push (0x110) is dropped, giving `ovf` = 1 and `drop_cnt` = 1.
  - Draining then yields exactly 0x100..0x10F.
- FIFO full with `dout_rdy` = 1 and `y_vld` = 1 for 10 cycles:
  - No drops, and `count` stays at 16.
  - The output order continues without a gap.
- Flush asserted together with `y_vld` at count = 5:
  - Next cycle shows `count` = 0, `dout_vld` = 0 and `ovf` = 0.
  - The following 8 samples are discarded again.
- `reset` pulsed low mid-drain at count = 7:
  - All outputs are 0 immediately.
  - After release, warm-up restarts from 0.
- 300 drops with `dout_rdy` held 0: `drop_cnt` saturates at 255 and `ovf` stays 1.
